// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int unsigned MaxN = 64;

  // Callers truncate the result to their own requester count.
  function automatic logic [MaxN-1:0] onehot(input int unsigned idx);
    logic [MaxN-1:0] v;
    v = {{(MaxN-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requester blocks and the arbiter.
interface rr_arbiter_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;

  modport master (
    output request,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  request,
    output grant,
    output grant_valid,
    output grant_id
  );
endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first enabled request at or after ptr, modulo N.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [N-1:0]   eff;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;

  always_comb begin
    eff   = req & mask;
    // Rotating right by ptr puts the highest-priority requester at bit 0.
    dbl   = {eff, eff} >> ptr;
    rot   = dbl[N-1:0];
    found = |rot;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i[IDW-1:0];
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (32'(sum) >= N) sum = sum - (IDW+1)'(N);
    idx = sum[IDW-1:0];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold and a starvation limit on consecutive owner cycles.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_if.slave  bus
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

  logic [N-1:0]   owner_oh;
  logic [N-1:0]   win_oh;
  logic [N-1:0]   pick_mask;
  logic           others;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] nxt_ptr;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req  (bus.request),
    .mask (pick_mask),
    .ptr  (ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    owner_oh  = N'(onehot(32'(grant_id_q)));
    win_oh    = N'(onehot(32'(pick_idx)));
    others    = |(bus.request & ~owner_oh);
    // While busy the owner is excluded, which only matters for forced rotation.
    pick_mask = (state_q == ARB_BUSY) ? ~owner_oh : {N{1'b1}};
    nxt_ptr   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;

    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d    = win_oh;
          grant_id_d = pick_idx;
          ptr_d      = nxt_ptr;
          hold_cnt_d = HCW'(1);
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (bus.request[grant_id_q] && (!others || hold_cnt_q < HCW'(MAX_HOLD))) begin
          if (hold_cnt_q < HCW'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (others) begin
          grant_d    = win_oh;
          grant_id_d = pick_idx;
          ptr_d      = nxt_ptr;
          hold_cnt_d = HCW'(1);
        end else begin
          grant_d    = '0;
          grant_id_d = '0;
          hold_cnt_d = '0;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: directed scenarios followed by random request traffic.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int MAX_WAIT = (N - 1) * MAX_HOLD + 1;

  logic clk;
  logic rst;

  rr_arbiter_if #(.N(N)) bus ();

  rr_arbiter #(
    .N       (N),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic         v;
    logic [1:0]   id;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;

  // Reference state: who owns the resource, whose turn is next, how long the owner has held it.
  int   m_owner;
  int   m_ptr;
  int   m_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic award(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % N;
    m_hold  = 1;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    bit others;
    if (m_owner < 0) begin
      if (r != 0) award(pick(r, -1));
    end else begin
      others = (r & ~(N'(1) << m_owner)) != 0;
      if (r[m_owner] && (!others || m_hold < MAX_HOLD)) begin
        if (m_hold < MAX_HOLD) m_hold++;
      end else if (r[m_owner]) begin
        award(pick(r, m_owner));
      end else if (others) begin
        award(pick(r, -1));
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end
  endtask

  // Model: advance on every edge and queue the grant the DUT must present after it.
  initial begin
    exp_t e;
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
      end else begin
        model_step(bus.request);
      end
      e.g  = (m_owner < 0) ? '0 : N'(1) << m_owner;
      e.v  = (m_owner >= 0);
      e.id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      q.push_back(e);
    end
  end

  // Monitor: pop and compare mid-cycle, and enforce the rule-level invariants.
  initial begin
    exp_t         e;
    logic [N-1:0] prev_req;
    int           waits[N];
    int           worst;
    prev_req = '0;
    foreach (waits[i]) waits[i] = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant", 32'(bus.grant), 32'(e.g));
        chk("grant_valid", 32'(bus.grant_valid), 32'(e.v));
        chk("grant_id", 32'(bus.grant_id), 32'(e.id));
      end
      chk("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
      chk("grant_to_requester", 32'(bus.grant & ~prev_req), 32'd0);
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (!rst && prev_req[i] && !bus.grant[i]) waits[i]++;
        else waits[i] = 0;
        if (waits[i] > worst) worst = waits[i];
      end
      chk("max_wait", 32'(worst <= MAX_WAIT), 32'd1);
      prev_req = bus.request;
    end
  end

  // Called at posedge+1: drive r, then let n edges sample it.
  task automatic apply(input logic [N-1:0] r, input int n);
    bus.request = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] flip;
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.request = '0;
    #1;
    chk("reset_grant", 32'(bus.grant), 32'd0);
    chk("reset_valid", 32'(bus.grant_valid), 32'd0);
    chk("reset_id", 32'(bus.grant_id), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // All requesters from reset: four cycles each in turn.
    apply(4'b1111, 20);
    apply(4'b0000, 2);
    // Single request held three cycles.
    apply(4'b0001, 3);
    apply(4'b0000, 2);
    // Owner 1 drops while 3 waits: direct handover.
    apply(4'b0010, 2);
    apply(4'b1010, 2);
    apply(4'b1000, 3);
    apply(4'b0000, 2);
    // Sole requester keeps its grant past the hold limit.
    apply(4'b0010, 10);
    apply(4'b0000, 2);
    // Owner 3 then 0 joins: rotation wraps to 0.
    apply(4'b1000, 2);
    apply(4'b1001, 8);
    apply(4'b0000, 2);

    // Asynchronous reset mid-grant.
    apply(4'b1111, 3);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", 32'(bus.grant), 32'd0);
    chk("async_rst_valid", 32'(bus.grant_valid), 32'd0);
    chk("async_rst_id", 32'(bus.grant_id), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(4'b0100, 2);
    // ptr now 3, so 3 wins the handover ahead of 0 and 1.
    apply(4'b1011, 3);
    apply(4'b0000, 2);

    // Random traffic: requests persist, each bit toggling with probability 1/4 per cycle.
    r = '0;
    for (int c = 0; c < 800; c++) begin
      flip = '0;
      for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 3) == 0);
      r = r ^ flip;
      apply(r, 1);
    end
    apply(4'b0000, 3);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
